count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_pkg.sv | 21 ++
 rtl/count_step_cmp.sv | 35 +++
 rtl/count_monitor.sv | 96 +++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared types for the count monitor: tracking FSM states and step classes.
// Latency: n/a (types only).
// Backpressure: n/a.
package count_pkg;

  // Tracking state of the monitor.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // no sample held
    ST_ACQ       = 2'd1,  // one sample held, direction unknown
    ST_LOCK_UP   = 2'd2,
    ST_LOCK_DOWN = 2'd3
  } state_t;

  // Classification of a new sample relative to the previous one.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_t;

endpackage

// File: rtl/count_step_cmp.sv
// Classifies data against prev as a +1 / -1 modular step, or neither.
// Latency: combinational.
// Backpressure: none.
// Ports: prev - previously accepted sample; data - new sample; step - class.
module count_step_cmp
  import count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] data,
  output step_t            step
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;

  // Natural WIDTH-bit wrap gives the max->0 and 0->max steps for free;
  // adding all-ones is subtracting one modulo 2^WIDTH.
  assign prev_inc = prev + ONE;
  assign prev_dec = prev + ALL_ONES;

  always_comb begin
    step = STEP_NONE;
    if (data == prev_inc) begin
      step = STEP_UP;
    end else if (data == prev_dec) begin
      step = STEP_DOWN;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Watches samples of an up/down counter, locks onto its direction and flags illegal steps.
// Latency: 1 cycle from a valid sample to the registered outputs.
// Backpressure: none; every valid sample is consumed, clear_i discards a same-cycle sample.
// Ports: clk, rst_n (async, active low); data_i/valid_i sample in; clear_i sync clear;
//        locked_o, dir_o level status; rev_o, err_o one-cycle pulses; err_cnt_o saturating count.
module count_monitor
  import count_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             dir_o,
  output logic             rev_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  step_t            step;

  count_step_cmp #(
    .WIDTH(WIDTH)
  ) u_step_cmp (
    .prev(prev),
    .data(data_i),
    .step(step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prev      <= '0;
      locked_o  <= 1'b0;
      dir_o     <= 1'b0;
      rev_o     <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      rev_o <= 1'b0;
      err_o <= 1'b0;
      if (clear_i) begin
        // dir_o and prev are left alone: dir_o is only meaningful while
        // locked, and prev is overwritten by the first sample out of IDLE.
        state     <= ST_IDLE;
        locked_o  <= 1'b0;
        err_cnt_o <= '0;
      end else if (valid_i) begin
        prev <= data_i;
        unique case (state)
          ST_IDLE: begin
            state <= ST_ACQ;
          end
          ST_ACQ: begin
            if (step == STEP_UP) begin
              state    <= ST_LOCK_UP;
              locked_o <= 1'b1;
              dir_o    <= 1'b1;
            end else if (step == STEP_DOWN) begin
              state    <= ST_LOCK_DOWN;
              locked_o <= 1'b1;
              dir_o    <= 1'b0;
            end
          end
          ST_LOCK_UP, ST_LOCK_DOWN: begin
            if (step == STEP_NONE) begin
              state    <= ST_ACQ;
              locked_o <= 1'b0;
              err_o    <= 1'b1;
              if (err_cnt_o != ERR_MAX) begin
                err_cnt_o <= err_cnt_o + 1'b1;
              end
            end else begin
              state <= (step == STEP_UP) ? ST_LOCK_UP : ST_LOCK_DOWN;
              dir_o <= (step == STEP_UP);
              // A reversal is a legal step whose direction differs from the lock.
              rev_o <= ((step == STEP_UP) != (state == ST_LOCK_UP));
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
